// File: rtl/mips32_pkg.sv
// mips32_pkg: shared size encodings, responder FSM state type and big-endian byte-lane enables
package mips32_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   // Lane 3 holds bits [31:24], so byte offset 0 maps to the top lane (big-endian)
   function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
      return size == SZ_BYTE ? 4'b1000 >> off
           : size == SZ_HALF ? (off[1] ? 4'b0011 : 4'b1100)
           : size == SZ_WORD ? 4'b1111 : 4'b0000;
   endfunction
endpackage

// File: rtl/mips32_dmem_array.sv
// mips32_dmem_array: single-port word RAM with synchronous read and per-byte write enables
module mips32_dmem_array #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);
   logic [31:0] mem [2**ADDR_W];
   always_ff @(posedge clk)
      if (en) begin
         if (we)
            for (int i = 0; i < 4; i++)
               if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         rdata <= mem[addr];
      end
endmodule

// File: rtl/mips32_dmem_responder.sv
// mips32_dmem_responder: MEM-stage load/store responder with fixed wait states and big-endian data RAM
module mips32_dmem_responder
   import mips32_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        stall
);
   localparam int CW = WAIT_STATES > 1 ? $clog2(WAIT_STATES) : 1;
   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic          lat_we, lat_signed;
   logic [1:0]    lat_size;
   logic [31:0]   lat_addr, lat_wdata;
   logic          idle, cur_we, cur_err, enter_resp;
   logic [1:0]    cur_size;
   logic [31:0]   cur_addr, cur_wdata, wlane, ram_rdata, ldata;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;

   // With zero wait states the RAM access happens on the acceptance edge, so the live request is used
   assign idle      = state == IDLE;
   assign cur_we    = idle ? req_we    : lat_we;
   assign cur_size  = idle ? req_size  : lat_size;
   assign cur_addr  = idle ? req_addr  : lat_addr;
   assign cur_wdata = idle ? req_wdata : lat_wdata;
   assign cur_err   = cur_size == 2'b11 || (cur_size == SZ_HALF && cur_addr[0]) ||
                      (cur_size == SZ_WORD && cur_addr[1:0] != 2'b00) || (|cur_addr[31:ADDR_W+2]);
   assign enter_resp = state_nx == RESP && state != RESP;
   assign wlane = cur_size == SZ_BYTE ? {4{cur_wdata[7:0]}}
                : cur_size == SZ_HALF ? {2{cur_wdata[15:0]}} : cur_wdata;
   assign stall = req_valid & ~rsp_valid;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         lat_we     <= 1'b0;
         lat_signed <= 1'b0;
         lat_size   <= SZ_BYTE;
         lat_addr   <= '0;
         lat_wdata  <= '0;
      end else begin
         state <= state_nx;
         if (idle && req_valid) begin
            cnt        <= CW'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
            lat_we     <= req_we;
            lat_signed <= req_signed;
            lat_size   <= req_size;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
         end else if (state == WAIT)
            cnt <= cnt - 1'b1;
      end

   always_comb
      state_nx = idle ? (req_valid ? (WAIT_STATES > 0 ? WAIT : RESP) : IDLE)
               : state == WAIT ? (cnt == '0 ? RESP : WAIT) : IDLE;

   always_comb begin
      ld_byte   = 8'(ram_rdata >> {~lat_addr[1:0], 3'b000});
      ld_half   = lat_addr[1] ? ram_rdata[15:0] : ram_rdata[31:16];
      ldata     = lat_size == SZ_BYTE ? {{24{lat_signed & ld_byte[7]}}, ld_byte}
                : lat_size == SZ_HALF ? {{16{lat_signed & ld_half[15]}}, ld_half} : ram_rdata;
      req_ready = idle;
      rsp_valid = state == RESP;
      rsp_err   = rsp_valid & cur_err;
      rsp_rdata = rsp_valid & ~cur_err & ~lat_we ? ldata : '0;
   end

   mips32_dmem_array #(.ADDR_W(ADDR_W)) u_array (
      .clk   (clk),
      .en    (enter_resp & ~cur_err),
      .we    (cur_we),
      .be    (lane_en(cur_size, cur_addr[1:0])),
      .addr  (cur_addr[ADDR_W+1:2]),
      .wdata (wlane),
      .rdata (ram_rdata)
   );
endmodule

// File: tb/tb_mips32_dmem_responder.sv
// tb_mips32_dmem_responder: directed checks of a 2-wait-state and a zero-wait-state responder
module tb_mips32_dmem_responder;
   logic        clk = 1'b0, reset = 1'b0;
   logic        r_valid = 1'b0, r_we = 1'b0, r_signed = 1'b0;
   logic [1:0]  r_size = 2'b00;
   logic [31:0] r_addr = '0, r_wdata = '0;
   logic        r_ready, r_rsp_valid, r_err, r_stall;
   logic [31:0] r_rdata;
   logic        z_valid = 1'b0, z_we = 1'b0, z_signed = 1'b0;
   logic [1:0]  z_size = 2'b00;
   logic [31:0] z_addr = '0, z_wdata = '0;
   logic        z_ready, z_rsp_valid, z_err, z_stall;
   logic [31:0] z_rdata;
   int          vectors = 0, miscompares = 0;
   logic [31:0] rd;
   logic        er;
   int          lat;

   always #5 clk = ~clk;

   mips32_dmem_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut (
      .clk(clk), .reset(reset), .req_valid(r_valid), .req_we(r_we), .req_size(r_size),
      .req_signed(r_signed), .req_addr(r_addr), .req_wdata(r_wdata), .req_ready(r_ready),
      .rsp_valid(r_rsp_valid), .rsp_rdata(r_rdata), .rsp_err(r_err), .stall(r_stall));

   mips32_dmem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset), .req_valid(z_valid), .req_we(z_we), .req_size(z_size),
      .req_signed(z_signed), .req_addr(z_addr), .req_wdata(z_wdata), .req_ready(z_ready),
      .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata), .rsp_err(z_err), .stall(z_stall));

   // Drives one request on the 2-wait-state instance; latency counts negedges after the acceptance edge
   task automatic access(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic scramble,
                         output logic [31:0] rdata, output logic err, output int latency);
      @(negedge clk);
      r_we = we; r_size = size; r_signed = sgn; r_addr = addr; r_wdata = wdata; r_valid = 1'b1;
      latency = 99; rdata = 32'h0; err = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (scramble) begin r_addr = ~addr; r_size = 2'b11; r_we = ~we; r_wdata = 32'h0; end
         if (r_rsp_valid) begin latency = n; rdata = r_rdata; err = r_err; break; end
      end
      r_valid = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      vectors++; if (r_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", r_ready); end
      vectors++; if (r_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b exp 0", r_rsp_valid); end
      vectors++; if (r_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", r_rdata); end
      vectors++; if (r_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", r_err); end
      vectors++; if (r_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall_idle got %b exp 0", r_stall); end
      r_valid = 1'b1; #1;
      vectors++; if (r_stall !== 1'b1) begin miscompares++; $display("FAIL reset_stall_follow got %b exp 1", r_stall); end
      r_valid = 1'b0;
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_word;
      access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, rd, er, lat);
      vectors++; if (lat !== 3) begin miscompares++; $display("FAIL word_store_latency got %0d exp 3", lat); end
      vectors++; if ({er, rd} !== {1'b0, 32'h0}) begin miscompares++; $display("FAIL word_store_rsp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
      @(negedge clk);
      vectors++; if ({r_rsp_valid, r_ready} !== 2'b01) begin miscompares++; $display("FAIL strobe_one_cycle got valid=%b ready=%b exp 0 1", r_rsp_valid, r_ready); end
      access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat);
      vectors++; if (lat !== 3) begin miscompares++; $display("FAIL word_load_latency got %0d exp 3", lat); end
      vectors++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin miscompares++; $display("FAIL word_load got err=%b rdata=%h exp err=0 rdata=deadbeef", er, rd); end
   endtask

   task automatic test_byte;
      access(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000007F, 1'b0, rd, er, lat);
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL byte_store_err got %b exp 0", er); end
      access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, rd, er, lat);
      vectors++; if (rd !== 32'hFFFFFFAD) begin miscompares++; $display("FAIL byte_load_signed got %h exp ffffffad", rd); end
      access(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0, rd, er, lat);
      vectors++; if (rd !== 32'h0000007F) begin miscompares++; $display("FAIL byte_load_unsigned got %h exp 0000007f", rd); end
      access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, rd, er, lat);
      vectors++; if (rd !== 32'h000000EF) begin miscompares++; $display("FAIL byte_load_off3 got %h exp 000000ef", rd); end
      access(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 1'b0, rd, er, lat);
      vectors++; if (rd !== 32'hDEAD7FEF) begin miscompares++; $display("FAIL byte_merge_word got %h exp dead7fef", rd); end
   endtask

   task automatic test_half;
      access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, rd, er, lat);
      vectors++; if (rd !== 32'hFFFFDEAD) begin miscompares++; $display("FAIL half_load_signed got %h exp ffffdead", rd); end
      access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, rd, er, lat);
      vectors++; if (rd !== 32'h00007FEF) begin miscompares++; $display("FAIL half_load_low got %h exp 00007fef", rd); end
      access(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b0, rd, er, lat);
      vectors++; if ({er, rd} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL half_misaligned got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
      access(1'b1, 2'b01, 1'b0, 32'h14, 32'h0000CAFE, 1'b0, rd, er, lat);
      access(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, rd, er, lat);
      vectors++; if (rd[31:16] !== 16'hCAFE) begin miscompares++; $display("FAIL half_store_hi got %h exp cafe", rd[31:16]); end
      access(1'b1, 2'b10, 1'b0, 32'h12, 32'h11111111, 1'b0, rd, er, lat);
      vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL word_store_misaligned_err got %b exp 1", er); end
      access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat);
      vectors++; if (rd !== 32'hDEAD7FEF) begin miscompares++; $display("FAIL misaligned_store_untouched got %h exp dead7fef", rd); end
   endtask

   task automatic test_errors;
      access(1'b0, 2'b10, 1'b0, 32'h00001000, 32'h0, 1'b0, rd, er, lat);
      vectors++; if ({er, rd} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL out_of_range got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
      vectors++; if (lat !== 3) begin miscompares++; $display("FAIL err_latency got %0d exp 3", lat); end
      access(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat);
      vectors++; if ({er, rd} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL size_illegal got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
      access(1'b0, 2'b10, 1'b0, 32'h00000FFC, 32'h0, 1'b0, rd, er, lat);
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL top_word_in_range got err=%b exp 0", er); end
   endtask

   task automatic test_latch;
      access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, rd, er, lat);
      vectors++; if ({er, rd} !== {1'b0, 32'hDEAD7FEF}) begin miscompares++; $display("FAIL latched_request got err=%b rdata=%h exp err=0 rdata=dead7fef", er, rd); end
   endtask

   task automatic test_zero_wait;
      @(negedge clk);
      z_we = 1'b1; z_size = 2'b10; z_addr = 32'h20; z_wdata = 32'h11223344; z_valid = 1'b1; #1;
      vectors++; if ({z_stall, z_rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL zw_store_pending got stall=%b valid=%b exp 1 0", z_stall, z_rsp_valid); end
      @(negedge clk);
      vectors++; if ({z_rsp_valid, z_err, z_stall} !== 3'b100) begin miscompares++; $display("FAIL zw_store_rsp got valid=%b err=%b stall=%b exp 1 0 0", z_rsp_valid, z_err, z_stall); end
      z_valid = 1'b0;
      @(negedge clk);
      vectors++; if ({z_rsp_valid, z_stall, z_ready} !== 3'b001) begin miscompares++; $display("FAIL zw_idle got valid=%b stall=%b ready=%b exp 0 0 1", z_rsp_valid, z_stall, z_ready); end
      z_we = 1'b0; z_valid = 1'b1; #1;
      vectors++; if (z_stall !== 1'b1) begin miscompares++; $display("FAIL zw_load_stall got %b exp 1", z_stall); end
      @(negedge clk);
      vectors++; if ({z_rsp_valid, z_stall} !== 2'b10) begin miscompares++; $display("FAIL zw_load_rsp got valid=%b stall=%b exp 1 0", z_rsp_valid, z_stall); end
      vectors++; if (z_rdata !== 32'h11223344) begin miscompares++; $display("FAIL zw_load_data got %h exp 11223344", z_rdata); end
      z_valid = 1'b0;
   endtask

   task automatic test_reset_wait;
      logic seen;
      access(1'b1, 2'b10, 1'b0, 32'h30, 32'hAAAAAAAA, 1'b0, rd, er, lat);
      @(negedge clk);
      r_we = 1'b1; r_size = 2'b10; r_addr = 32'h30; r_wdata = 32'h12345678; r_valid = 1'b1;
      @(negedge clk);
      vectors++; if ({r_ready, r_stall} !== 2'b01) begin miscompares++; $display("FAIL wait_state got ready=%b stall=%b exp 0 1", r_ready, r_stall); end
      reset = 1'b0; #1;
      vectors++; if ({r_ready, r_rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL reset_in_wait got ready=%b valid=%b exp 1 0", r_ready, r_rsp_valid); end
      r_valid = 1'b0;
      seen = 1'b0;
      repeat (3) begin @(negedge clk); seen = seen | r_rsp_valid; end
      reset = 1'b1;
      repeat (3) begin @(negedge clk); seen = seen | r_rsp_valid; end
      vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL reset_no_response got %b exp 0", seen); end
      access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, rd, er, lat);
      vectors++; if (rd !== 32'hAAAAAAAA) begin miscompares++; $display("FAIL reset_store_discarded got %h exp aaaaaaaa", rd); end
   endtask

   initial begin
      test_reset;
      test_word;
      test_byte;
      test_half;
      test_errors;
      test_latch;
      test_zero_wait;
      test_reset_wait;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mips32_dmem_responder.md
# mips32_dmem_responder

Memory-side responder for the MIPS32 pipeline's MEM-stage load/store port. Accepts one request at a time over a valid/ready handshake, inserts a fixed number of wait states, and performs big-endian byte, halfword or word accesses on an internal word-organised data RAM. Returns load data or a store acknowledge with a one-cycle response strobe, and drives a stall to freeze the pipeline while an access is outstanding.

## Interface
- ADDR_W, 10: word-address bits; RAM depth is 2^ADDR_W 32-bit words.
- WAIT_STATES, 2: extra cycles between acceptance and response (0 allowed).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- req_valid  in  1  request present; held stable until rsp_valid
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal
- req_signed  in  1  sign-extend byte/halfword loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_ready  out  1  high only in IDLE
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid; misaligned, out-of-range or illegal size
- stall  out  1  req_valid & ~rsp_valid (combinational)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch we/size/signed/addr/wdata; go to WAIT if WAIT_STATES>0, else RESP.
- WAIT: count down WAIT_STATES cycles, then RESP.
- RESP: rsp_valid=1 for exactly one cycle; return to IDLE next edge. No new request is accepted in RESP.
- Byte order big-endian: offset 0 → bits [31:24], offset 3 → [7:0]; halfword offset 0 → [31:16], offset 2 → [15:0].
- Error checks on latched request: halfword with addr[0]≠0, word with addr[1:0]≠0, size 11, or addr[31:ADDR_W+2]≠0 → rsp_err=1, rsp_rdata=0, RAM untouched.
- Stores: byte enables derived from size and addr[1:0]; write committed on the edge that enters RESP. Only enabled lanes change.
- Loads: RAM read issued on the edge entering RESP; rsp_rdata lane-selected and zero- or sign-extended per req_signed; word loads ignore req_signed.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values: req_ready=1 (FSM in IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0; stall follows req_valid.
- Latency: acceptance edge at cycle 0 → rsp_valid high during cycle WAIT_STATES+1. Throughput one access per WAIT_STATES+2 cycles.
- Back-to-back: a request held after its response is treated as new in IDLE; the MEM stage must drop or change req_valid on the cycle after rsp_valid.
- Reset during WAIT: FSM to IDLE, pending store discarded (not committed), no response issued.
- Reset in RESP: store already committed; rsp_valid drops immediately.
- Changes to req_* after acceptance are ignored (latched copy used).

## Structure
- Shared package mips32_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state type, byte-lane enable function.
- Sub-module mips32_dmem_array: single-port 2^ADDR_W×32 RAM, synchronous read and write, 4 byte-write enables.
- Responder top holds FSM, wait counter, request latch, error check and load alignment/extension.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load 0x10 (WAIT_STATES=2) → rsp_valid in cycle 3 after each acceptance, rdata 0xDEADBEEF, err 0.
- After above, byte store 0x7F to 0x12, signed byte load 0x11 → 0xFFFFFFAD; unsigned byte load 0x12 → 0x0000007F; word load 0x10 → 0xDEAD7FEF.
- Signed half load 0x10 → 0xFFFFDEAD; half load 0x11 → err=1, rdata 0; word store to 0x12 → err=1, word at 0x10 unchanged.
- Address 0x00001000 with ADDR_W=10 → err=1; req_size=11 → err=1.
- WAIT_STATES=0: store then load at 0x20 → rsp_valid one cycle after each acceptance; stall high exactly in cycles req_valid & ~rsp_valid.
- Assert reset during WAIT of a word store 0x12345678 to 0x30 (prior content 0xAAAAAAAA) → no rsp_valid, req_ready=1 immediately, later load 0x30 returns 0xAAAAAAAA.
